ahb_arbiter: RTL
================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter MAX_BEATS, default 8, giving the maximum number of consecutive granted data beats before forced re-arbitration (range 1-255).
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0, giving the master index parked on when no master requests (range 0-2).
REQ-004 SHALL have port HCLK  input  1  bus clock; all state changes on rising edge.
REQ-005 SHALL have port HRESET  input  1  synchronous active-high reset.
REQ-006 SHALL have port HBUSREQ  input  3  per-master bus request; bit i = master i.
REQ-007 SHALL have port HLOCK  input  3  per-master locked-transfer request.
REQ-008 SHALL have port HTRANS  input  2  transfer type of the current bus owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-009 SHALL have port HREADY  input  1  bus ready fed back from the bridge.
REQ-010 SHALL have port HGRANT  output  3  one-hot grant, registered.
REQ-011 SHALL have port HMASTER  output  2  index of the address-phase owner, registered.
REQ-012 SHALL have port HMASTLOCK  output  1  current address-phase transfer is locked, registered.

Function
REQ-013 SHALL implement states PARK (no requests, DEFAULT_MASTER granted), GRANT (requesting master owns bus) and LOCKED (owner holds HLOCK).
REQ-014 SHALL hold every register unchanged in any cycle with HREADY=0.
REQ-015 SHALL treat as an arbitration point a cycle where HREADY=1, state is not LOCKED, and one of: HTRANS=IDLE, HBUSREQ[owner]=0, or beat count = MAX_BEATS.
REQ-016 SHALL at an arbitration point select the first requester searching round-robin from HMASTER+1 modulo 3, the current owner being searched last.
REQ-017 SHALL at an arbitration point with HBUSREQ=000 grant DEFAULT_MASTER and enter PARK.
REQ-018 SHALL drive the new HGRANT one cycle after the arbitration point; HGRANT SHALL always be one-hot.
REQ-019 SHALL update HMASTER to the granted index on the first HREADY=1 edge on which HGRANT differs from one-hot(HMASTER), giving exactly one cycle between HGRANT change and HMASTER change when HREADY=1.
REQ-020 SHALL count beats: increment on HREADY=1 with HTRANS NONSEQ or SEQ; clear to 0 on any HGRANT change; saturate at MAX_BEATS.
REQ-021 SHALL not re-arbitrate on HTRANS=BUSY alone.
REQ-022 SHALL enter LOCKED from GRANT when HLOCK[owner]=1 on an HREADY=1 cycle, ignoring beat count and other requests while LOCKED.
REQ-023 SHALL exit LOCKED to GRANT on the HREADY=1 cycle after HLOCK[owner] falls, so the final locked transfer completes before any handover.
REQ-024 SHALL, on simultaneous requests from all masters with owner 2, grant order 0,1,2.
REQ-025 SHALL load HMASTLOCK with HLOCK[granted] at the same edge HMASTER updates.

Reset
REQ-026 SHALL on HRESET=1 at a clock edge set state PARK, HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0, beat count 0, regardless of HREADY.
REQ-027 SHALL, when reset occurs mid-LOCKED or mid-burst, abandon the burst; the first grant after reset follows REQ-016 from DEFAULT_MASTER.

Configuration
REQ-028 SHALL provide macro ARB_LOCK_EN; when defined, REQ-022, REQ-023 and REQ-025 apply.
REQ-029 SHALL, without ARB_LOCK_EN, ignore HLOCK, omit the LOCKED state and tie HMASTLOCK to 0.

Verification
REQ-030 SHALL cover reset: HRESET=1 two cycles with HBUSREQ=111 -> HGRANT=001, HMASTER=0, HMASTLOCK=0.
REQ-031 SHALL cover round-robin: HBUSREQ=111, HTRANS=IDLE, HREADY=1 from owner 0 -> HGRANT 010, 100, 001 on successive arbitration points; HMASTER lags HGRANT by one cycle.
REQ-032 SHALL cover beat limit: MAX_BEATS=4, master 1 requesting with SEQ beats, master 2 requesting -> grant moves to 100 one cycle after 4th beat.
REQ-033 SHALL cover wait states: HREADY=0 for 3 cycles at an arbitration point -> HGRANT, HMASTER, beat count unchanged until HREADY=1.
REQ-034 SHALL cover lock (ARB_LOCK_EN): master 0 HLOCK=1 for 10 SEQ beats, MAX_BEATS=4, HBUSREQ=011 -> HGRANT stays 001, HMASTLOCK=1; grant moves to 010 after HLOCK falls plus one transfer; without macro, moves after 4 beats.
REQ-035 SHALL cover park: HBUSREQ falls to 000 while master 2 owns -> HGRANT=001 next cycle, state PARK.

Source files
------------

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Three-master AHB bus arbiter with round-robin selection, a per-owner beat
// limit that forces re-arbitration, parking on a default master when nobody
// requests, and optional locked-transfer support.
//
// Optional feature macro: ARB_LOCK_EN
//   defined   : HLOCK is honoured, the LOCKED state exists and HMASTLOCK is
//               driven from a register.
//   undefined : HLOCK is ignored, there is no LOCKED state and HMASTLOCK is 0.
//
// Parameters
//   MAX_BEATS      consecutive data beats before forced re-arbitration (1-255)
//   DEFAULT_MASTER master parked on when no master requests (0-2)
//
// Ports
//   HCLK       in   1  bus clock, all state changes on the rising edge
//   HRESET     in   1  synchronous active-high reset
//   HBUSREQ    in   3  per-master bus request, bit i = master i
//   HLOCK      in   3  per-master locked-transfer request
//   HTRANS     in   2  transfer type of the current owner (IDLE/BUSY/NONSEQ/SEQ)
//   HREADY     in   1  bus ready; every register holds while it is low
//   HGRANT     out  3  one-hot grant, registered
//   HMASTER    out  2  address-phase owner index, registered
//   HMASTLOCK  out  1  current address-phase transfer is locked, registered
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int unsigned MAX_BEATS      = 8,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [2:0] HBUSREQ,
    input  logic [2:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic [2:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam logic [1:0] DEF_IDX = DEFAULT_MASTER[1:0];
    localparam logic [7:0] MAX_CNT = MAX_BEATS[7:0];

    localparam logic [1:0] TR_IDLE = 2'b00;

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_GRANT = 2'd1
    } state_t;
`endif

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] v;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] gnt_idx(input logic [2:0] g);
        logic [1:0] v;
        case (g)
            3'b010:  v = 2'd1;
            3'b100:  v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    // First requester searching from last+1 modulo 3; last is checked last.
    function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] last);
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
        logic [1:0] v;
        case (last)
            2'd0: begin
                o0 = 2'd1; o1 = 2'd2; o2 = 2'd0;
            end
            2'd1: begin
                o0 = 2'd2; o1 = 2'd0; o2 = 2'd1;
            end
            default: begin
                o0 = 2'd0; o1 = 2'd1; o2 = 2'd2;
            end
        endcase
        if ((req & onehot(o0)) != 3'b000) begin
            v = o0;
        end else if ((req & onehot(o1)) != 3'b000) begin
            v = o1;
        end else begin
            v = o2;
        end
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t     state_q,  state_d;
    logic [2:0] grant_q,  grant_d;
    logic [1:0] master_q, master_d;
    logic [7:0] beat_q,   beat_d;
`ifdef ARB_LOCK_EN
    logic       mastlock_q, mastlock_d;
    logic       owner_lock;
`else
    logic       unused_hlock;
    assign unused_hlock = ^HLOCK;
`endif

    logic owner_req;
    logic handover;
    logic arb_cond;
    logic arb_point;

    // Requests/locks are masked with the owner's one-hot rather than indexed,
    // so an impossible HMASTER value can never select an undefined bit.
    assign owner_req = |(HBUSREQ & onehot(master_q));
`ifdef ARB_LOCK_EN
    assign owner_lock = |(HLOCK & onehot(master_q));
`endif

    // A new grant has been issued but the address phase still belongs to the
    // previous owner.
    assign handover = (grant_q != onehot(master_q));

    // PARK has no real owner, so any ready cycle there may hand the bus out.
    assign arb_cond = (state_q == ST_PARK) || (HTRANS == TR_IDLE) ||
                      !owner_req || (beat_q == MAX_CNT);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        master_d  = master_q;
        beat_d    = beat_q;
        arb_point = 1'b0;
`ifdef ARB_LOCK_EN
        mastlock_d = mastlock_q;
`endif

        if (HREADY) begin
`ifdef ARB_LOCK_EN
            if (state_q == ST_LOCKED) begin
                // The cycle in which HLOCK drops is still the final locked
                // transfer; handover can only be considered from GRANT next.
                if (!owner_lock) begin
                    state_d    = ST_GRANT;
                    mastlock_d = 1'b0;
                end
            end else if (state_q == ST_GRANT && owner_lock && !handover) begin
                // Lock only once the owner really holds the address phase.
                state_d    = ST_LOCKED;
                mastlock_d = 1'b1;
            end else begin
                arb_point = arb_cond;
            end
`else
            arb_point = arb_cond;
`endif

            if (arb_point) begin
                if (HBUSREQ == 3'b000) begin
                    grant_d = onehot(DEF_IDX);
                    state_d = ST_PARK;
                end else begin
                    grant_d = onehot(rr_pick(HBUSREQ, master_q));
                    state_d = ST_GRANT;
                end
            end

            if (handover) begin
                master_d = gnt_idx(grant_q);
`ifdef ARB_LOCK_EN
                mastlock_d = |(HLOCK & grant_q);
`endif
            end

            // HTRANS[1] marks NONSEQ/SEQ; BUSY and IDLE are not beats.
            if (grant_d != grant_q) begin
                beat_d = 8'd0;
            end else if (HTRANS[1] && beat_q != MAX_CNT) begin
                beat_d = beat_q + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (HRESET) begin
            state_q  <= ST_PARK;
            grant_q  <= onehot(DEF_IDX);
            master_q <= DEF_IDX;
            beat_q   <= 8'd0;
`ifdef ARB_LOCK_EN
            mastlock_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            beat_q   <= beat_d;
`ifdef ARB_LOCK_EN
            mastlock_q <= mastlock_d;
`endif
        end
    end

    assign HGRANT  = grant_q;
    assign HMASTER = master_q;
`ifdef ARB_LOCK_EN
    assign HMASTLOCK = mastlock_q;
`else
    assign HMASTLOCK = 1'b0;
`endif

endmodule
